// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Four-requester round-robin arbiter that drives the select lines of a
// downstream MUX_4to1. One requester owns the mux at a time. Ownership ends
// when the owner strobes done, or when it drops its request. The next search
// starts one position past the last owner, so a requester that keeps its
// request asserted yields to any other pending requester.
//
// Optional feature (compile-time macro MUX_ARB_TIMEOUT_EN):
//   When defined, a hold counter limits each ownership to HOLD_MAX GRANT
//   cycles. When the limit is reached, ownership is revoked and timeout
//   pulses for one cycle. When undefined, no counter exists, timeout is
//   tied low and ownership is unbounded.
//
// Parameters:
//   HOLD_MAX  GRANT cycles allowed per ownership with the timeout feature
//             (legal range 2..255).
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req[3:0] in   request vector, bit i selects mux input in<i>
//   done     in   single-cycle release strobe from the current owner
//   grant    out  one-hot registered grant, zero when nobody owns the mux
//   s0       out  mux select MSB (registered)
//   s1       out  mux select LSB (registered); {s0,s1} = owner index
//   busy     out  high while the FSM is in GRANT
//   timeout  out  one-cycle pulse on forced revocation
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [3:0] grant_reg;
  logic [1:0] sel_reg;     // owner index while in GRANT, last owner in IDLE
  logic       busy_reg;
  logic [1:0] ptr_reg;     // first index searched in the next arbitration

  logic [1:0] scan_idx;
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic [3:0] pick_onehot;
  logic       release_now;
  logic       hold_expired;

  // An out-of-range HOLD_MAX shows up as this named scope in the elaborated
  // hierarchy. The scope is empty so that it never changes any logic.
  if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_out_of_range
  end

  // Rotating priority search: look at ptr, ptr+1, ptr+2 and ptr+3 (mod 4),
  // and take the first requester that is set.
  always_comb begin
    scan_idx   = '0;
    pick_idx   = ptr_reg;
    pick_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_reg + 2'(k);
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick_idx == 2'(gi));
  end

  // done and the owner dropping its request in the same cycle count as one
  // release, because both simply feed this OR.
  assign release_now = done | ~req[sel_reg];

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_reg;
  logic       timeout_reg;

  assign hold_expired = (hold_cnt_reg == 8'(HOLD_MAX));

  // hold_cnt_reg holds 1 during the first GRANT cycle. A release in the
  // same cycle as expiry takes priority, so no timeout pulse is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (state_reg == IDLE) begin
        hold_cnt_reg <= pick_valid ? 8'd1 : 8'd0;
      end else if (release_now) begin
        hold_cnt_reg <= '0;
      end else if (hold_expired) begin
        hold_cnt_reg <= '0;
        timeout_reg  <= 1'b1;
      end else begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // done is not looked at here, so a strobe while IDLE does nothing.
          if (pick_valid) begin
            state_reg <= GRANT;
            grant_reg <= pick_onehot;
            sel_reg   <= pick_idx;
            busy_reg  <= 1'b1;
          end else begin
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end
        end
        GRANT: begin
          // Other requests are ignored while a grant is held. Leaving GRANT
          // always passes through at least one IDLE cycle before a new grant.
          if (release_now || hold_expired) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            ptr_reg   <= sel_reg + 2'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_reg;
  assign s0    = sel_reg[1];
  assign s1    = sel_reg[0];
  assign busy  = busy_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_fail;

  mux_rr_arbiter #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .s0      (s0),
    .s1      (s1),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full output check. sel is {s0,s1}.
  task automatic check_all(input string name, input logic [3:0] eg, input logic [1:0] es,
                           input logic eb, input logic et);
    check({name, " grant"}, int'(grant), int'(eg));
    check({name, " sel"}, int'({s0, s1}), int'(es));
    check({name, " busy"}, int'(busy), int'(eb));
    check({name, " timeout"}, int'(timeout), int'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  // Fresh reset, starting and ending away from a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    done     = 1'b0;

    //             req      done  grant    sel    busy
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0}; // idle
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1}; // single request
    vecs[2]  = '{4'b0100, 1'b1, 4'b0000, 2'b10, 1'b0}; // done, ptr->3
    vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 2'b10, 1'b0}; // done while idle
    vecs[4]  = '{4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1}; // scan 3 -> 0
    vecs[5]  = '{4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1}; // hold
    vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 2'b00, 1'b0}; // req[0] drop, ptr->1
    vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 2'b01, 1'b1}; // owner 1
    vecs[8]  = '{4'b1111, 1'b0, 4'b0010, 2'b01, 1'b1}; // hold vs 1111
    vecs[9]  = '{4'b1111, 1'b0, 4'b0010, 2'b01, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 2'b01, 1'b0}; // done, ptr->2
    vecs[11] = '{4'b1111, 1'b0, 4'b0100, 2'b10, 1'b1}; // owner 2
    vecs[12] = '{4'b1011, 1'b0, 4'b0000, 2'b10, 1'b0}; // req[2] drop, ptr->3
    vecs[13] = '{4'b1011, 1'b0, 4'b1000, 2'b11, 1'b1}; // owner 3
    vecs[14] = '{4'b0001, 1'b0, 4'b0000, 2'b11, 1'b0}; // req[3] drop, ptr->0
    vecs[15] = '{4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1}; // pending 0 granted
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0}; // done+drop = one release
    vecs[17] = '{4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1}; // ptr=1, only 0 pending
    vecs[18] = '{4'b0011, 1'b1, 4'b0000, 2'b00, 1'b0}; // release, ptr->1
    vecs[19] = '{4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1}; // 0 still high, 1 wins
    vecs[20] = '{4'b0001, 1'b0, 4'b0000, 2'b01, 1'b0}; // req[1] drop, ptr->2
    vecs[21] = '{4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1}; // owner 0
    vecs[22] = '{4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0}; // holds req through release
    vecs[23] = '{4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1}; // regranted, alone
    vecs[24] = '{4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0}; // drop

    // Reset state
    #2;
    check_all("reset_async", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick();
    check_all("reset_clocked", 4'b0000, 2'b00, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      check($sformatf("vec%0d grant", i), int'(grant), int'(vecs[i].grant));
      check($sformatf("vec%0d sel", i), int'({s0, s1}), int'(vecs[i].sel));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("vec%0d timeout", i), int'(timeout), 0);
      $display("vec%0d req=%b done=%b -> grant=%b sel=%b%b busy=%b", i,
               vecs[i].req, vecs[i].done, grant, s0, s1, busy);
    end
    done = 1'b0;

    // Fairness: req=1111 held, done in every 3rd GRANT cycle
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all($sformatf("fair%0d c1", k), onehot(k % 4), 2'(k % 4), 1'b1, 1'b0);
      tick();
      check_all($sformatf("fair%0d c2", k), onehot(k % 4), 2'(k % 4), 1'b1, 1'b0);
      tick();
      check_all($sformatf("fair%0d c3", k), onehot(k % 4), 2'(k % 4), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_all($sformatf("fair%0d rel", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      $display("fair%0d grant=%b released", k, onehot(k % 4));
    end

    // Reset mid-GRANT with owner 2, no clock edge needed
    do_reset();
    req = 4'b0100;
    tick();
    check_all("rst_mid pre", 4'b0100, 2'b10, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("rst_mid async", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick();
    check_all("rst_mid held", 4'b0000, 2'b00, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    check_all("rst_mid rearb", 4'b0100, 2'b10, 1'b1, 1'b0);
    $display("reset mid-grant sequence done");

    // Owner 0 never releases
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_all($sformatf("hold c%0d", c), 4'b0001, 2'b00, 1'b1, 1'b0);
    end
`ifdef MUX_ARB_TIMEOUT_EN
    tick();
    check_all("timeout revoke", 4'b0000, 2'b00, 1'b0, 1'b1);
    tick();
    check_all("timeout regrant", 4'b0001, 2'b00, 1'b1, 1'b0);
    for (int c = 2; c <= 7; c++) tick();
    check_all("timeout c7", 4'b0001, 2'b00, 1'b1, 1'b0);
    tick();
    check_all("timeout c8", 4'b0001, 2'b00, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_all("release at limit", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick();
    check_all("after release at limit", 4'b0001, 2'b00, 1'b1, 1'b0);
`else
    for (int c = 9; c <= 40; c++) begin
      tick();
      check_all($sformatf("nolimit c%0d", c), 4'b0001, 2'b00, 1'b1, 1'b0);
    end
`endif
    $display("hold/timeout sequence done");

    req = 4'b0000;
    tick();
    check_all("final idle", 4'b0000, 2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
